// File: rtl/reg_rename_table.sv
// reg_rename_table: speculative register alias table (RAT) with an in-order
// release queue. At rename, each instruction reads its source mappings, takes
// a physical register from the free list for rd, and records the mapping it
// superseded. At commit, that superseded mapping goes back to the free list.
//
// Optional build macro: REG_RENAME_STATS_EN adds the stat_renames_o and
// stat_stall_cycles_o saturating 32-bit counters.
//
// Timing summary:
//   rename result  : registered, one cycle after fire
//   free-list pop  : combinational, same cycle as fire
//   free-list push : registered, one cycle after commit pop
module reg_rename_table #(
  parameter  int PREG_W   = 7,
  parameter  int RQ_DEPTH = 64,
  localparam int CNT_W    = $clog2(RQ_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  // decode side
  input  logic              rename_valid_i,
  output logic              rename_ready_o,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rd_i,
  // dispatch side
  output logic              out_valid_o,
  output logic [PREG_W-1:0] rs1_preg_o,
  output logic [PREG_W-1:0] rs2_preg_o,
  output logic [PREG_W-1:0] rd_preg_o,
  output logic [PREG_W-1:0] old_rd_preg_o,
  // ROB commit side
  input  logic              commit_valid_i,
  output logic              commit_ready_o,
  output logic [CNT_W-1:0]  rq_count_o,
  // free list
  input  logic [PREG_W-1:0] fl_free_reg_num_i,
  input  logic              fl_empty_i,
  input  logic              fl_full_i,
  output logic              fl_take_next_free_o,
  output logic              fl_reg_freed_o,
  output logic [PREG_W-1:0] fl_freed_reg_num_o,
  output logic              release_overflow_o
`ifdef REG_RENAME_STATS_EN
  ,
  output logic [31:0]       stat_renames_o,
  output logic [31:0]       stat_stall_cycles_o
`endif
);

  localparam int PTR_W = $clog2(RQ_DEPTH);
  localparam int ENT_W = PREG_W + 1;

  // ---------------------------------------------------------------------------
  // Register alias table
  // ---------------------------------------------------------------------------
  logic [PREG_W-1:0] rat_q [32];

  // ---------------------------------------------------------------------------
  // Release queue: each entry is {has_dest, superseded physical register}
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0]  rq_mem_q [RQ_DEPTH];
  logic [PTR_W-1:0]  rq_head_q, rq_head_d;
  logic [PTR_W-1:0]  rq_tail_q, rq_tail_d;
  logic [CNT_W-1:0]  rq_count_q, rq_count_d;

  logic              rq_full;
  logic              rq_empty;
  logic              rd_nonzero;
  logic              fire;
  logic              pop;
  logic [ENT_W-1:0]  push_entry;
  logic [ENT_W-1:0]  head_entry;
  logic [PREG_W-1:0] old_rd_map;

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic              out_valid_q;
  logic [PREG_W-1:0] rs1_preg_q;
  logic [PREG_W-1:0] rs2_preg_q;
  logic [PREG_W-1:0] rd_preg_q;
  logic [PREG_W-1:0] old_rd_preg_q;
  logic              fl_reg_freed_q;
  logic [PREG_W-1:0] fl_freed_reg_num_q;
  logic              release_overflow_q;

  // Acceptance and queue handshake decode.
  always_comb begin
    rq_full    = (rq_count_q == CNT_W'(RQ_DEPTH));
    rq_empty   = (rq_count_q == '0);
    rd_nonzero = (rd_i != 5'd0);
    // x0 instructions need no free register, so they are not held up by an
    // empty free list; they still need a queue slot to keep commit order.
    rename_ready_o      = !rq_full && (!rd_nonzero || !fl_empty_i);
    fire                = rename_valid_i && rename_ready_o;
    fl_take_next_free_o = fire && rd_nonzero;
    commit_ready_o      = !rq_empty;
    pop                 = commit_valid_i && !rq_empty;
    old_rd_map          = rat_q[rd_i];
    push_entry          = {rd_nonzero, old_rd_map};
    head_entry          = rq_mem_q[rq_head_q];
  end

  // Next-state for the queue pointers and occupancy; a simultaneous push and
  // pop leaves the count unchanged.
  always_comb begin
    rq_head_d  = rq_head_q;
    rq_tail_d  = rq_tail_q;
    rq_count_d = rq_count_q;
    if (fire) begin
      rq_tail_d = rq_tail_q + PTR_W'(1);
    end
    if (pop) begin
      rq_head_d = rq_head_q + PTR_W'(1);
    end
    case ({fire, pop})
      2'b10:   rq_count_d = rq_count_q + CNT_W'(1);
      2'b01:   rq_count_d = rq_count_q - CNT_W'(1);
      default: rq_count_d = rq_count_q;
    endcase
  end

  // RAT update: identity on reset, rd takes the free-list head on fire.
  // Entry 0 is never written, so x0 always maps to physical register 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rat_q[i] <= PREG_W'(i);
      end
    end else if (fl_take_next_free_o) begin
      rat_q[rd_i] <= fl_free_reg_num_i;
    end
  end

  // Release queue storage. Contents need no reset: the pointers and count
  // define which entries are live.
  always_ff @(posedge clock) begin
    if (fire) begin
      rq_mem_q[rq_tail_q] <= push_entry;
    end
  end

  // Release queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rq_head_q  <= '0;
      rq_tail_q  <= '0;
      rq_count_q <= '0;
    end else begin
      rq_head_q  <= rq_head_d;
      rq_tail_q  <= rq_tail_d;
      rq_count_q <= rq_count_d;
    end
  end

  // Rename result: sources read the table before this instruction's own
  // write, so rs1 == rd returns the superseded mapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      rs1_preg_q    <= '0;
      rs2_preg_q    <= '0;
      rd_preg_q     <= '0;
      old_rd_preg_q <= '0;
    end else begin
      out_valid_q <= fire;
      if (fire) begin
        rs1_preg_q    <= rat_q[rs1_i];
        rs2_preg_q    <= rat_q[rs2_i];
        rd_preg_q     <= rd_nonzero ? fl_free_reg_num_i : '0;
        old_rd_preg_q <= old_rd_map;
      end
    end
  end

  // Release to the free list one cycle after the pop; entries without a
  // destination produce no pulse and leave the last freed number in place.
  always_ff @(posedge clock) begin
    if (reset) begin
      fl_reg_freed_q     <= 1'b0;
      fl_freed_reg_num_q <= '0;
    end else begin
      fl_reg_freed_q <= pop && head_entry[ENT_W-1];
      if (pop && head_entry[ENT_W-1]) begin
        fl_freed_reg_num_q <= head_entry[PREG_W-1:0];
      end
    end
  end

  // Sticky overflow: a release driven while the free list reports full is
  // dropped by the free list, which means a register has leaked.
  always_ff @(posedge clock) begin
    if (reset) begin
      release_overflow_q <= 1'b0;
    end else if (fl_reg_freed_q && fl_full_i) begin
      release_overflow_q <= 1'b1;
    end
  end

  assign out_valid_o        = out_valid_q;
  assign rs1_preg_o         = rs1_preg_q;
  assign rs2_preg_o         = rs2_preg_q;
  assign rd_preg_o          = rd_preg_q;
  assign old_rd_preg_o      = old_rd_preg_q;
  assign rq_count_o         = rq_count_q;
  assign fl_reg_freed_o     = fl_reg_freed_q;
  assign fl_freed_reg_num_o = fl_freed_reg_num_q;
  assign release_overflow_o = release_overflow_q;

`ifdef REG_RENAME_STATS_EN
  logic [31:0] stat_renames_q;
  logic [31:0] stat_stall_cycles_q;
  logic        stall;

  // A stall is a cycle where decode offers an instruction that cannot be taken.
  always_comb begin
    stall = rename_valid_i && !rename_ready_o;
  end

  // Saturating rename and stall counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_renames_q      <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      if (fire && (stat_renames_q != 32'hFFFF_FFFF)) begin
        stat_renames_q <= stat_renames_q + 32'd1;
      end
      if (stall && (stat_stall_cycles_q != 32'hFFFF_FFFF)) begin
        stat_stall_cycles_q <= stat_stall_cycles_q + 32'd1;
      end
    end
  end

  assign stat_renames_o      = stat_renames_q;
  assign stat_stall_cycles_o = stat_stall_cycles_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_reg_rename_table.sv
// Testbench for reg_rename_table. The bench plays the free list: it
// supplies fl_free_reg_num from its own counter and keeps a reference RAT
// and release queue. Expected rename results and expected releases are
// queued when stimulus is driven, then popped when the DUT produces them.
module tb_reg_rename_table;

  localparam int PREG_W   = 7;
  localparam int RQ_DEPTH = 64;
  localparam int CNT_W    = $clog2(RQ_DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rename_valid = 1'b0;
  logic              rename_ready_o;
  logic [4:0]        rs1 = '0, rs2 = '0, rd = '0;
  logic              out_valid_o;
  logic [PREG_W-1:0] rs1_preg_o, rs2_preg_o, rd_preg_o, old_rd_preg_o;
  logic              commit_valid = 1'b0;
  logic              commit_ready_o;
  logic [CNT_W-1:0]  rq_count_o;
  logic [PREG_W-1:0] fl_free_reg_num = '0;
  logic              fl_empty = 1'b0, fl_full = 1'b0;
  logic              fl_take_next_free_o;
  logic              fl_reg_freed_o;
  logic [PREG_W-1:0] fl_freed_reg_num_o;
  logic              release_overflow_o;
`ifdef REG_RENAME_STATS_EN
  logic [31:0]       stat_renames_o, stat_stall_cycles_o;
`endif

  reg_rename_table #(.PREG_W(PREG_W), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clock               (clock),
    .reset               (reset),
    .rename_valid_i      (rename_valid),
    .rename_ready_o      (rename_ready_o),
    .rs1_i               (rs1),
    .rs2_i               (rs2),
    .rd_i                (rd),
    .out_valid_o         (out_valid_o),
    .rs1_preg_o          (rs1_preg_o),
    .rs2_preg_o          (rs2_preg_o),
    .rd_preg_o           (rd_preg_o),
    .old_rd_preg_o       (old_rd_preg_o),
    .commit_valid_i      (commit_valid),
    .commit_ready_o      (commit_ready_o),
    .rq_count_o          (rq_count_o),
    .fl_free_reg_num_i   (fl_free_reg_num),
    .fl_empty_i          (fl_empty),
    .fl_full_i           (fl_full),
    .fl_take_next_free_o (fl_take_next_free_o),
    .fl_reg_freed_o      (fl_reg_freed_o),
    .fl_freed_reg_num_o  (fl_freed_reg_num_o),
    .release_overflow_o  (release_overflow_o)
`ifdef REG_RENAME_STATS_EN
    ,
    .stat_renames_o      (stat_renames_o),
    .stat_stall_cycles_o (stat_stall_cycles_o)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [PREG_W-1:0] mrat [32];
  logic [PREG_W:0]   mrq [$];                 // {has_dest, old}
  logic [4*PREG_W-1:0] exp_out [$];           // {rs1, rs2, rd, old}
  logic [PREG_W-1:0] exp_rel [$];
  logic [PREG_W-1:0] mfree = 7'd32;
  int                mcount = 0;
  int                mren   = 0;
  int                mstall = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  logic [4*PREG_W-1:0] mon_o;
  logic [PREG_W-1:0]   mon_r;
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid_o) begin
        if (exp_out.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
        else begin
          mon_o = exp_out.pop_front();
          chk("rs1_preg",    32'(rs1_preg_o),    32'(mon_o[4*PREG_W-1:3*PREG_W]));
          chk("rs2_preg",    32'(rs2_preg_o),    32'(mon_o[3*PREG_W-1:2*PREG_W]));
          chk("rd_preg",     32'(rd_preg_o),     32'(mon_o[2*PREG_W-1:PREG_W]));
          chk("old_rd_preg", 32'(old_rd_preg_o), 32'(mon_o[PREG_W-1:0]));
        end
      end
      if (fl_reg_freed_o) begin
        if (exp_rel.size() == 0) chk("freed_unexpected", 32'd1, 32'd0);
        else begin
          mon_r = exp_rel.pop_front();
          chk("freed_reg_num", 32'(fl_freed_reg_num_o), 32'(mon_r));
        end
      end
    end
  end

  // Drive one cycle of stimulus at posedge+1, check combinational outputs,
  // update the model, and advance to the next posedge+1.
  task automatic drive(input logic rv, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic cv);
    logic exp_rdy, fire, pop;
    logic [PREG_W:0] e;
    rename_valid    = rv;
    rs1             = a;
    rs2             = b;
    rd              = d;
    commit_valid    = cv;
    fl_free_reg_num = mfree;
    #1;
    exp_rdy = (mcount < RQ_DEPTH) && ((d == 5'd0) || !fl_empty);
    fire    = rv && exp_rdy;
    pop     = cv && (mcount != 0);
    if (rv) chk("rename_ready", 32'(rename_ready_o), 32'(exp_rdy));
    chk("take_next_free", 32'(fl_take_next_free_o), 32'(fire && (d != 5'd0)));
    chk("commit_ready", 32'(commit_ready_o), 32'(mcount != 0));
    chk("rq_count", 32'(rq_count_o), 32'(mcount));
    if (rv && !exp_rdy) mstall++;
    if (pop) begin
      e = mrq.pop_front();
      if (e[PREG_W]) exp_rel.push_back(e[PREG_W-1:0]);
    end
    if (fire) begin
      exp_out.push_back({mrat[a], mrat[b], (d != 5'd0) ? mfree : 7'd0, mrat[d]});
      mrq.push_back({d != 5'd0, mrat[d]});
      if (d != 5'd0) begin
        mrat[d] = mfree;
        mfree   = mfree + 7'd1;
      end
      mren++;
    end
    mcount = mcount + int'(fire) - int'(pop);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rename_valid = 1'b0;
    commit_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) mrat[i] = PREG_W'(i);
    mrq.delete();
    mcount = 0;
    mren   = 0;
    mstall = 0;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_rq_count", 32'(rq_count_o), 32'd0);
    chk("rst_fl_reg_freed", 32'(fl_reg_freed_o), 32'd0);
    chk("rst_overflow", 32'(release_overflow_o), 32'd0);
    chk("rst_rd_preg", 32'(rd_preg_o), 32'd0);
    chk("rst_freed_num", 32'(fl_freed_reg_num_o), 32'd0);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * RQ_DEPTH && mcount > 0; i++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("drain_count", 32'(mcount), 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // rename x5 with x5 as source; following renames see the new mapping
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    // commit all three: only the first releases (old x5 -> p5)
    drain();

    // empty free list blocks only instructions with a destination
    fl_empty = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
    fl_empty = 1'b0;
    drain();

    // fill the release queue, then try a rename alongside a commit
    for (int i = 0; i < RQ_DEPTH; i++)
      drive(1'b1, 5'(i % 32), 5'((i + 1) % 32), 5'(1 + i % 31), 1'b0);
    drive(1'b1, 5'd2, 5'd3, 5'd4, 1'b1);
    drive(1'b1, 5'd2, 5'd3, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // random mix of renames and commits across pointer wrap
    for (int i = 0; i < 200; i++) begin
      fl_empty = ($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0));
    end
    fl_empty = 1'b0;
    drain();

    // release into a full free list sets the sticky overflow
    chk("overflow_clear", 32'(release_overflow_o), 32'd0);
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0);
    fl_full = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("overflow_set", 32'(release_overflow_o), 32'd1);
    fl_full = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("overflow_sticky", 32'(release_overflow_o), 32'd1);

    // reset with entries in flight: no releases, RAT back to identity
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b0);
    drive(1'b1, 5'd9, 5'd2, 5'd10, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // three stalls then two renames (x9 must map back to p9)
    fl_empty = 1'b1;
    repeat (3) drive(1'b1, 5'd1, 5'd1, 5'd3, 1'b0);
    fl_empty = 1'b0;
    drive(1'b1, 5'd9, 5'd10, 5'd9, 1'b0);
    drive(1'b1, 5'd9, 5'd10, 5'd10, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef REG_RENAME_STATS_EN
    chk("stat_renames", stat_renames_o, 32'(mren));
    chk("stat_stall_cycles", stat_stall_cycles_o, 32'(mstall));
`endif
    drain();

    chk("out_left", 32'(exp_out.size()), 32'd0);
    chk("rel_left", 32'(exp_rel.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
